seven_seg_serializer: RTL and testbench
=======================================

# seven_seg_serializer

Downstream stage of the seven-segment display path: accepts four BCD digits from the binary-to-BCD converter, encodes each to a segment pattern, and shifts the resulting 32-bit word out serially to a chain of four 74HC595-style shift registers, then pulses the storage latch. It owns the physical `seg_data`/`seg_clk`/`seg_latch` pins and runs one transfer per accepted `valid` pulse.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `seg_clk` half-period; legal range 1..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  one-cycle request to display the current digit inputs.
- `thousands`  in  4  BCD digit, leftmost display.
- `hundreds`  in  4  BCD digit.
- `tens`  in  4  BCD digit.
- `ones`  in  4  BCD digit, rightmost display.
- `busy`  out  1  high while a transfer is in progress.
- `seg_data`  out  1  serial data to shift-register chain.
- `seg_clk`  out  1  shift clock; chain samples on its rising edge.
- `seg_latch`  out  1  storage-register latch pulse, active-high.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE: `busy`=0, `seg_clk`=0, `seg_latch`=0. On `valid`=1, snapshot four encoded digits into a 32-bit shift word {thousands, hundreds, tens, ones}, go to SHIFT.
- Segment byte per digit: {dp,g,f,e,d,c,b,a}, active-high, dp always 0.
- Codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; inputs 0xA–0xF encode to 0x40 (dash).
- SHIFT: 32 bits, MSB first (bit 31 = thousands dp). Per bit: low phase of CLK_DIV cycles with `seg_data` driven, then high phase of CLK_DIV cycles with `seg_clk`=1 and `seg_data` held. After bit 0's high phase go to LATCH.
- LATCH: `seg_clk`=0, `seg_latch`=1 for CLK_DIV cycles, then IDLE.
- `valid` while `busy`=1 is ignored and dropped; digit inputs are don't-care outside the accept cycle.
- Bit counter 5 bits (31 down to 0), phase counter 8 bits; no wrap beyond bit 0.

## Timing
- Reset: next edge forces IDLE; `busy`, `seg_data`, `seg_clk`, `seg_latch` all 0; shift word cleared. Reset mid-transfer aborts with no latch pulse; chain contents are undefined but display output is unchanged.
- Accept edge = cycle 0; `busy`=1 and bit 31 on `seg_data` from cycle 1.
- First `seg_clk` rise at cycle 1+CLK_DIV; bit n rises at cycle 1+(2·(31−n)+1)·CLK_DIV.
- `seg_data` changes only while `seg_clk`=0; stable ≥CLK_DIV cycles before each rise and through the high phase.
- `seg_latch` high cycles 1+64·CLK_DIV .. 65·CLK_DIV; `busy` high for exactly 65·CLK_DIV cycles.
- `busy` falls in the same cycle IDLE is entered; a `valid` in that cycle is accepted (back-to-back transfers, no dead cycle).
- `valid` and `rst` together: reset wins.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined: leading zero digits encode to 0x00 (blank). `thousands` blanked if 0; `hundreds` if it and all higher digits are 0; `tens` likewise; `ones` never blanked. Dash digits (>9) are not zero and stop blanking.
- Undefined: every digit encoded per the code table, zeros shown as 0x3F.

## Test plan
- CLK_DIV=1, digits 1,2,3,4 -> 32 sampled bits = 0x065B4F66, one `seg_latch` pulse of 1 cycle, `busy` high 65 cycles.
- Digits 0,0,0,7 -> word 0x00000007 with `SEG_LEADING_ZERO_BLANK_EN`, 0x3F3F3F07 without; digits 0,0,0,0 -> 0x0000003F / 0x3F3F3F3F.
- Digits 0xA,9,0xF,0 -> 0x406F403F (both builds).
- `valid` with 5,5,5,5 then `valid` with 1,1,1,1 at cycle 10 -> only 0x6D6D6D6D shifted, single latch pulse; `valid` on the cycle `busy` falls -> second transfer starts next cycle.
- `rst` asserted at cycle 20 of a transfer -> all outputs 0 next cycle, no `seg_latch`; subsequent `valid` with 8,8,8,8 -> 0x7F7F7F7F.
- CLK_DIV=4 -> `seg_clk` period 8 cycles, `seg_data` stable ≥4 cycles before each rise, `busy` high 260 cycles, latch 4 cycles.

Source files
------------

// File: rtl/seven_seg_serializer_if.sv
// Request/handshake bundle between the BCD converter and the seven-segment serializer:
// four BCD digits plus a one-cycle valid, with busy returned to the producer.
interface seven_seg_serializer_if;
    logic       valid;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;

    modport master (
        output valid,
        output thousands,
        output hundreds,
        output tens,
        output ones,
        input  busy
    );

    modport slave (
        input  valid,
        input  thousands,
        input  hundreds,
        input  tens,
        input  ones,
        output busy
    );
endinterface

// File: rtl/seven_seg_serializer.sv
// Encodes four BCD digits to segment bytes and shifts them MSB-first into a 74HC595 chain, then latches.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_serializer #(
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    seven_seg_serializer_if.slave        bus,
    output logic                         seg_data,
    output logic                         seg_clk,
    output logic                         seg_latch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = 8'h40;
        endcase
        return code;
    endfunction

    state_t      state_r;
    logic [31:0] shift_r;
    logic [4:0]  bit_r;
    logic [7:0]  phase_r;
    logic        busy_r;
    logic        seg_data_r;
    logic        seg_clk_r;
    logic        seg_latch_r;

    logic [31:0] word_s;
    logic        blank_th_s;
    logic        blank_hu_s;
    logic        blank_te_s;

    // Build the 32-bit display word from the live digit inputs (used only on the accept cycle).
    always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank_th_s = (bus.thousands == 4'd0);
        blank_hu_s = blank_th_s && (bus.hundreds == 4'd0);
        blank_te_s = blank_hu_s && (bus.tens == 4'd0);
`else
        blank_th_s = 1'b0;
        blank_hu_s = 1'b0;
        blank_te_s = 1'b0;
`endif
        word_s = {blank_th_s ? 8'h00 : seg_encode(bus.thousands),
                  blank_hu_s ? 8'h00 : seg_encode(bus.hundreds),
                  blank_te_s ? 8'h00 : seg_encode(bus.tens),
                  seg_encode(bus.ones)};
    end

    // Transfer FSM: each bit is a low phase then a high phase of CLK_DIV cycles, then a latch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= 32'h0000_0000;
            bit_r       <= 5'd31;
            phase_r     <= 8'd0;
            busy_r      <= 1'b0;
            seg_data_r  <= 1'b0;
            seg_clk_r   <= 1'b0;
            seg_latch_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    seg_clk_r   <= 1'b0;
                    seg_latch_r <= 1'b0;
                    phase_r     <= 8'd0;
                    bit_r       <= 5'd31;
                    if (bus.valid) begin
                        shift_r    <= word_s;
                        seg_data_r <= word_s[31];
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy_r     <= 1'b0;
                        seg_data_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (phase_r == PHASE_LAST) begin
                        phase_r <= 8'd0;
                        if (!seg_clk_r) begin
                            seg_clk_r <= 1'b1;
                        end else begin
                            seg_clk_r <= 1'b0;
                            // shift_r[31] always holds the bit currently on seg_data
                            if (bit_r == 5'd0) begin
                                seg_data_r  <= 1'b0;
                                seg_latch_r <= 1'b1;
                                state_r     <= ST_LATCH;
                            end else begin
                                bit_r      <= bit_r - 5'd1;
                                shift_r    <= {shift_r[30:0], 1'b0};
                                seg_data_r <= shift_r[30];
                            end
                        end
                    end else begin
                        phase_r <= phase_r + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (phase_r == PHASE_LAST) begin
                        phase_r     <= 8'd0;
                        seg_latch_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        phase_r <= phase_r + 8'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    phase_r     <= 8'd0;
                    busy_r      <= 1'b0;
                    seg_data_r  <= 1'b0;
                    seg_clk_r   <= 1'b0;
                    seg_latch_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign seg_data  = seg_data_r;
    assign seg_clk   = seg_clk_r;
    assign seg_latch = seg_latch_r;

endmodule

// File: tb/tb_seven_seg_serializer.sv
// Bench for seven_seg_serializer: two instances (CLK_DIV=1 and 4) driven from vector tables and
// random digits, with the serial stream decoded and compared to a digit-level reference model.
module tb_seven_seg_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v   = 1'b0;
    logic       dsel = 1'b0;
    logic [3:0] d_th = 4'd0;
    logic [3:0] d_hu = 4'd0;
    logic [3:0] d_te = 4'd0;
    logic [3:0] d_on = 4'd0;

    int total = 0;
    int bad   = 0;

    seven_seg_serializer_if if1 ();
    seven_seg_serializer_if if4 ();

    assign if1.valid     = v & ~dsel;
    assign if4.valid     = v & dsel;
    assign if1.thousands = d_th;
    assign if1.hundreds  = d_hu;
    assign if1.tens      = d_te;
    assign if1.ones      = d_on;
    assign if4.thousands = d_th;
    assign if4.hundreds  = d_hu;
    assign if4.tens      = d_te;
    assign if4.ones      = d_on;

    logic sd1, sc1, sl1, sd4, sc4, sl4;

    seven_seg_serializer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .seg_data(sd1), .seg_clk(sc1), .seg_latch(sl1)
    );

    seven_seg_serializer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave),
        .seg_data(sd4), .seg_clk(sc4), .seg_latch(sl4)
    );

    logic m_busy, m_data, m_clk, m_latch;
    assign m_busy  = dsel ? if4.busy : if1.busy;
    assign m_data  = dsel ? sd4 : sd1;
    assign m_clk   = dsel ? sc4 : sc1;
    assign m_latch = dsel ? sl4 : sl1;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: look up each digit, then blank leading zeros when that build option is on.
    function automatic logic [31:0] model_word(input logic [3:0] th, input logic [3:0] hu,
                                               input logic [3:0] te, input logic [3:0] on);
        logic [7:0]  lut [10];
        logic [3:0]  dg  [4];
        logic [31:0] w;
        logic [7:0]  s;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        bit leading;
        leading = 1'b1;
`endif
        lut = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        dg  = '{th, hu, te, on};
        w   = 32'h0;
        for (int i = 0; i < 4; i++) begin
            s = (dg[i] > 4'd9) ? 8'h40 : lut[int'(dg[i])];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (leading && dg[i] == 4'd0 && i < 3) s = 8'h00;
            if (dg[i] != 4'd0) leading = 1'b0;
`endif
            w = {w[23:0], s};
        end
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at edge+1; accepts digits on the next edge and decodes the whole serial transfer.
    task automatic run_transfer(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                                input logic [3:0] on, input logic [31:0] exp,
                                input int drop_at, input int abort_at, input string tag);
        int cd;
        int budget;
        int c, rises, rise_err, stab_err, busy_cnt, latch_cnt, latch_first, last_chg;
        logic [31:0] got;
        logic pclk, pdata;
        cd = dsel ? 4 : 1;
        budget = 80 * cd + 10;
        d_th = th; d_hu = hu; d_te = te; d_on = on;
        v = 1'b1;
        @(posedge clk);
        #1;
        v = 1'b0;
        d_th = 4'($urandom); d_hu = 4'($urandom); d_te = 4'($urandom); d_on = 4'($urandom);
        c = 1; rises = 0; rise_err = 0; stab_err = 0; busy_cnt = 0; latch_cnt = 0;
        latch_first = -1; last_chg = 1; got = 32'h0; pclk = 1'b0; pdata = m_data;
        check({tag, " first_bit"}, {30'h0, m_busy, m_data}, {30'h0, 1'b1, exp[31]});
        while (c < budget) begin
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check({tag, " abort_outputs"}, {28'h0, m_busy, m_clk, m_data, m_latch}, 32'h0);
                check({tag, " abort_no_latch"}, latch_cnt, 32'd0);
                return;
            end
            if (!m_busy) break;
            busy_cnt++;
            if (m_latch) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = c;
            end
            if (m_data !== pdata) begin
                if (m_clk) stab_err++;
                last_chg = c;
            end
            if (m_clk && !pclk) begin
                if (rises < 32) begin
                    got[31 - rises] = m_data;
                    if (c != 1 + (2 * rises + 1) * cd) rise_err++;
                    if (c - last_chg < cd) stab_err++;
                end
                rises++;
            end
            pclk = m_clk;
            pdata = m_data;
            if (c == drop_at) begin
                v = 1'b1;
                d_th = 4'd1; d_hu = 4'd1; d_te = 4'd1; d_on = 4'd1;
            end else begin
                v = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        v = 1'b0;
        check({tag, " busy_released"}, {31'h0, m_busy}, 32'd0);
        check({tag, " word"}, got, exp);
        check({tag, " rises"}, rises, 32'd32);
        check({tag, " rise_timing_errs"}, rise_err, 32'd0);
        check({tag, " data_stability_errs"}, stab_err, 32'd0);
        check({tag, " busy_cycles"}, busy_cnt, 65 * cd);
        check({tag, " latch_cycles"}, latch_cnt, cd);
        check({tag, " latch_start"}, latch_first, 1 + 64 * cd);
    endtask

    typedef struct {
        logic [3:0]  th;
        logic [3:0]  hu;
        logic [3:0]  te;
        logic [3:0]  on;
        logic [31:0] exp;
        logic        sel;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 32'h065B4F66, 1'b0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd7, 32'h00000007, 1'b0};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 32'h0000003F, 1'b0};
        vecs[5] = '{4'd0, 4'd5, 4'd0, 4'd9, 32'h006D3F6F, 1'b1};
`else
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd7, 32'h3F3F3F07, 1'b0};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 32'h3F3F3F3F, 1'b0};
        vecs[5] = '{4'd0, 4'd5, 4'd0, 4'd9, 32'h3F6D3F6F, 1'b1};
`endif
        vecs[3] = '{4'hA, 4'd9, 4'hF, 4'd0, 32'h406F403F, 1'b0};
        vecs[4] = '{4'd1, 4'd2, 4'd3, 4'd4, 32'h065B4F66, 1'b1};

        idle(3);
        check("reset_outputs_div1", {28'h0, if1.busy, sc1, sd1, sl1}, 32'h0);
        check("reset_outputs_div4", {28'h0, if4.busy, sc4, sd4, sl4}, 32'h0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            dsel = vecs[i].sel;
            run_transfer(vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on, vecs[i].exp, -1, -1,
                         $sformatf("vec%0d", i));
            idle(1);
        end

        // valid during a transfer is dropped, not queued
        dsel = 1'b0;
        run_transfer(4'd5, 4'd5, 4'd5, 4'd5, 32'h6D6D6D6D, 10, -1, "drop");
        idle(3);
        check("drop_not_queued", {31'h0, m_busy}, 32'd0);

        // back-to-back: second valid lands in the cycle busy falls
        run_transfer(4'd1, 4'd2, 4'd3, 4'd4, 32'h065B4F66, -1, -1, "b2b_a");
        run_transfer(4'd9, 4'd8, 4'd7, 4'd6, 32'h6F7F077D, -1, -1, "b2b_b");
        dsel = 1'b1;
        run_transfer(4'd3, 4'd1, 4'd4, 4'd1, 32'h4F066606, -1, -1, "b2b4_a");
        run_transfer(4'd2, 4'd7, 4'd1, 4'd8, 32'h5B07067F, -1, -1, "b2b4_b");
        idle(2);

        // reset mid-transfer, then a clean transfer
        dsel = 1'b0;
        run_transfer(4'd5, 4'd6, 4'd7, 4'd8, 32'h6D7D077F, -1, 20, "abort");
        idle(3);
        check("abort_stays_idle", {30'h0, m_busy, m_latch}, 32'd0);
        run_transfer(4'd8, 4'd8, 4'd8, 4'd8, 32'h7F7F7F7F, -1, -1, "after_abort");
        idle(1);

        // reset wins over a simultaneous valid
        rst = 1'b1;
        v = 1'b1;
        d_th = 4'd1; d_hu = 4'd1; d_te = 4'd1; d_on = 4'd1;
        @(posedge clk);
        #1;
        check("rst_vs_valid", {31'h0, m_busy}, 32'd0);
        rst = 1'b0;
        v = 1'b0;
        @(posedge clk);
        #1;
        check("rst_vs_valid_after", {31'h0, m_busy}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] r [4];
            for (int k = 0; k < 4; k++) begin
                r[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            dsel = (i % 8 == 7);
            run_transfer(r[0], r[1], r[2], r[3], model_word(r[0], r[1], r[2], r[3]), -1, -1,
                         $sformatf("rnd%0d_%h%h%h%h", i, r[0], r[1], r[2], r[3]));
            idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
